// File: rtl/connection_block_dbuf.sv
// Double-buffered connection block: per-output track mux with optional
// output register. Configuration is shifted into a shadow register and
// only copied into the active register by a commit that sees exactly
// CFG_BITS shifts since the last commit attempt.
module connection_block_dbuf #(
  parameter int CHANNEL_ONEWAY_WIDTH = 4,
  parameter int NUM_OUTS             = 2
) (
  input  logic                            scan_clk,
  input  logic                            reset,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_0,
  input  logic [CHANNEL_ONEWAY_WIDTH-1:0] tracks_1,
  input  logic                            scan_en,
  input  logic                            scan_in,
  output logic                            scan_out,
  input  logic                            cfg_commit,
  output logic [NUM_OUTS-1:0]             out,
  output logic                            cfg_valid,
  output logic                            cfg_error
);

  localparam int MUX_SIZE = 2 * CHANNEL_ONEWAY_WIDTH / NUM_OUTS;
  localparam int SEL_BITS = $clog2(MUX_SIZE);
  localparam int FIELD    = SEL_BITS + 1;
  localparam int CFG_BITS = NUM_OUTS * FIELD;
  // Counter must hold CFG_BITS+1 so over-shifting stays distinguishable.
  localparam int CNT_W    = $clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    bit_cnt;
  logic [NUM_OUTS-1:0] out_q;
  logic [NUM_OUTS-1:0] mux_val;
  logic [NUM_OUTS-1:0] reg_en;
  logic                commit_ok;

  // Saturating increment: parks at CFG_BITS+1 so any excess shift is remembered.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == CNT_W'(CFG_BITS + 1))
      return cnt;
    return cnt + CNT_W'(1);
  endfunction

  assign commit_ok = cfg_commit && !scan_en && (bit_cnt == CNT_W'(CFG_BITS));
  assign scan_out  = shadow[0];

  // Shadow shift register; LSB-first so the first bit in lands at bit 0.
  always_ff @(posedge scan_clk) begin
    if (reset)
      shadow <= '0;
    else if (scan_en)
      shadow <= {scan_in, shadow[CFG_BITS-1:1]};
  end

  // Shift counter; every commit attempt restarts the count.
  always_ff @(posedge scan_clk) begin
    if (reset)
      bit_cnt <= '0;
    else if (cfg_commit)
      bit_cnt <= '0;
    else if (scan_en)
      bit_cnt <= sat_inc(bit_cnt);
  end

  // Active configuration and status flags, updated only on commit attempts.
  always_ff @(posedge scan_clk) begin
    if (reset) begin
      active    <= '0;
      cfg_valid <= 1'b0;
      cfg_error <= 1'b0;
    end else if (commit_ok) begin
      active    <= shadow;
      cfg_valid <= 1'b1;
      cfg_error <= 1'b0;
    end else if (cfg_commit) begin
      cfg_error <= 1'b1;
    end
  end

  // ---- stage boundary: combinational mux -> output register ----
  // Output register samples every mux each cycle regardless of reg_en.
  always_ff @(posedge scan_clk) begin
    if (reset)
      out_q <= '0;
    else
      out_q <= mux_val;
  end

  // Output k sees tracks k, k+NUM_OUTS, ... interleaved across both directions.
  for (genvar k = 0; k < NUM_OUTS; k++) begin : g_out
    logic [MUX_SIZE-1:0] mux_in;
    logic [SEL_BITS-1:0] sel;

    for (genvar j = 0; j < MUX_SIZE; j++) begin : g_in
      if (j % 2 == 0) begin : g_dir0
        assign mux_in[j] = tracks_0[k + NUM_OUTS * (j / 2)];
      end else begin : g_dir1
        assign mux_in[j] = tracks_1[k + NUM_OUTS * (j / 2)];
      end
    end

    assign sel        = active[k*FIELD +: SEL_BITS];
    assign reg_en[k]  = active[k*FIELD + SEL_BITS];
    assign mux_val[k] = mux_in[sel];
    assign out[k]     = cfg_valid & (reg_en[k] ? out_q[k] : mux_val[k]);
  end

endmodule

// File: tb/tb_connection_block_dbuf.sv
// Directed bench for connection_block_dbuf with default parameters
// (CFG_BITS = 6, LSB-first scan).
module tb_connection_block_dbuf;

  logic       scan_clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] tracks_0 = '0;
  logic [3:0] tracks_1 = '0;
  logic       scan_en = 1'b0;
  logic       scan_in = 1'b0;
  logic       scan_out;
  logic       cfg_commit = 1'b0;
  logic [1:0] out;
  logic       cfg_valid;
  logic       cfg_error;

  int checks = 0;
  int errors = 0;

  connection_block_dbuf dut (
    .scan_clk   (scan_clk),
    .reset      (reset),
    .tracks_0   (tracks_0),
    .tracks_1   (tracks_1),
    .scan_en    (scan_en),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .cfg_commit (cfg_commit),
    .out        (out),
    .cfg_valid  (cfg_valid),
    .cfg_error  (cfg_error)
  );

  always #5 scan_clk = ~scan_clk;

  // Advance one active edge, then settle 1 time unit past it.
  task automatic tick();
    @(posedge scan_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    scan_en = 1'b0;
    cfg_commit = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic shift_bit(input logic b);
    scan_en = 1'b1;
    scan_in = b;
    tick();
    scan_en = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  // Loads active = 6'b101010: out[0] <- t0[2] unregistered, out[1] <- t1[1] registered.
  task automatic load_101010();
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
  endtask

  // Loads active = 6'b011000: out[0] <- t0[0], out[1] <- t1[3], both unregistered.
  task automatic load_011000();
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0);
  endtask

  task automatic test_reset();
    tracks_0 = 4'($urandom);
    tracks_1 = 4'($urandom);
    reset = 1'b1;
    tick();
    tick();
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL reset_out: got %b want 00", out); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", cfg_valid); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", cfg_error); end
    checks++; if (scan_out !== 1'b0) begin errors++; $display("FAIL reset_scan_out: got %b want 0", scan_out); end
    reset = 1'b0;
  endtask

  task automatic test_good_load();
    do_reset();
    tracks_0 = 4'b0100;
    tracks_1 = 4'b0000;
    load_101010();
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL good_pre_commit_out: got %b want 00", out); end
    commit();
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL good_valid: got %b want 1", cfg_valid); end
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL good_error: got %b want 0", cfg_error); end
    checks++; if (out !== 2'b01) begin errors++; $display("FAIL good_out_commit: got %b want 01", out); end
    tracks_1 = 4'b0010;
    #1;
    checks++; if (out !== 2'b01) begin errors++; $display("FAIL good_reg_not_yet: got %b want 01", out); end
    tick();
    checks++; if (out !== 2'b11) begin errors++; $display("FAIL good_reg_after_edge: got %b want 11", out); end
    tracks_0 = 4'b0000;
    #1;
    checks++; if (out !== 2'b10) begin errors++; $display("FAIL good_comb_path: got %b want 10", out); end
    tracks_0 = 4'b1011;
    tracks_1 = 4'b1101;
    #1;
    checks++; if (out !== 2'b10) begin errors++; $display("FAIL good_wrong_tracks: got %b want 10", out); end
  endtask

  task automatic test_short_load();
    do_reset();
    tracks_0 = 4'b0001;
    tracks_1 = 4'b1000;
    shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0);
    shift_bit(1'b1); shift_bit(1'b1);
    commit();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL short_error: got %b want 1", cfg_error); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %b want 0", cfg_valid); end
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL short_out: got %b want 00", out); end
    load_011000();
    commit();
    checks++; if (cfg_error !== 1'b0) begin errors++; $display("FAIL short_reload_error: got %b want 0", cfg_error); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL short_reload_valid: got %b want 1", cfg_valid); end
    checks++; if (out !== 2'b11) begin errors++; $display("FAIL short_reload_out: got %b want 11", out); end
    tracks_0 = 4'b0000;
    #1;
    checks++; if (out !== 2'b10) begin errors++; $display("FAIL short_reload_t0: got %b want 10", out); end
  endtask

  task automatic test_commit_during_shift();
    do_reset();
    shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0);
    shift_bit(1'b0); shift_bit(1'b0);
    scan_en = 1'b1;
    scan_in = 1'b0;
    cfg_commit = 1'b1;
    tick();
    scan_en = 1'b0;
    cfg_commit = 1'b0;
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cds_error: got %b want 1", cfg_error); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL cds_valid: got %b want 0", cfg_valid); end
    checks++; if (scan_out !== 1'b1) begin errors++; $display("FAIL cds_sixth_shift: got %b want 1", scan_out); end
    commit();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL cds_followup_error: got %b want 1", cfg_error); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL cds_followup_valid: got %b want 0", cfg_valid); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    tracks_0 = 4'b0100;
    tracks_1 = 4'b0000;
    load_101010();
    commit();
    commit();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL b2b_error: got %b want 1", cfg_error); end
    checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", cfg_valid); end
    checks++; if (out !== 2'b01) begin errors++; $display("FAIL b2b_out: got %b want 01", out); end
  endtask

  task automatic test_overshift();
    do_reset();
    tracks_0 = 4'b0001;
    tracks_1 = 4'b1000;
    shift_bit(1'b1);
    load_011000();
    commit();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL over_error: got %b want 1", cfg_error); end
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL over_valid: got %b want 0", cfg_valid); end
  endtask

  task automatic test_shadow_isolation();
    do_reset();
    tracks_0 = 4'b0100;
    tracks_1 = 4'b0010;
    load_101010();
    commit();
    tick();
    checks++; if (out !== 2'b11) begin errors++; $display("FAIL iso_old_sel: got %b want 11", out); end
    for (int i = 0; i < 6; i++) begin
      shift_bit((i == 3 || i == 4) ? 1'b1 : 1'b0);
      checks++; if (out !== 2'b11) begin errors++; $display("FAIL iso_during_shift%0d: got %b want 11", i, out); end
    end
    commit();
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL iso_new_sel: got %b want 00", out); end
    tracks_0 = 4'b0001;
    tracks_1 = 4'b1000;
    #1;
    checks++; if (out !== 2'b11) begin errors++; $display("FAIL iso_new_tracks: got %b want 11", out); end
  endtask

  task automatic test_scan_passthrough();
    logic seq [12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                       1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      shift_bit(seq[k-1]);
      if (k >= 6) begin
        checks++;
        if (scan_out !== seq[k-6]) begin
          errors++;
          $display("FAIL scan_pass_shift%0d: got %b want %b", k, scan_out, seq[k-6]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    tracks_0 = 4'b1111;
    load_101010();
    reset = 1'b1;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    reset = 1'b0;
    checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b want 0", cfg_valid); end
    checks++; if (out !== 2'b00) begin errors++; $display("FAIL rmid_out: got %b want 00", out); end
    commit();
    checks++; if (cfg_error !== 1'b1) begin errors++; $display("FAIL rmid_cnt_cleared: got %b want 1", cfg_error); end
  endtask

  initial begin
    test_reset();
    test_good_load();
    test_short_load();
    test_commit_during_shift();
    test_back_to_back();
    test_overshift();
    test_shadow_isolation();
    test_scan_passthrough();
    test_reset_mid_commit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
